// File: rtl/alu_arb_seq.sv
// alu_arb_seq: shares one external ALU between two requesters.
// It arbitrates in IDLE, runs single-cycle ALU ops, and runs a shift-add
// multiply over several ALU cycles. Each accepted request returns exactly
// one tagged response.
//
// Optional feature macro: ALU_ARB_MUL_EN
//   defined   -> op 0010 runs the shift-add multiply (MUL_ADD / MUL_SHIFT states)
//   undefined -> op 0010 is reported as unsupported, and the multiply states are not built
//
// Handshake semantics (all ports):
//   A transfer happens on a rising edge where valid && ready are both 1.
//   A requester holds its valid and payload stable until it sees ready.
//   reqN_ready is combinational. It is high only in IDLE, for the granted requester.
//   resp_valid stays high, and resp_* stays stable, until a rising edge where resp_ready=1.
//
// Latency is counted in edges, including the accepting edge:
//   single op = 2, multiply = 2*WIDTH+1, unsupported = 1.
// dbg_state exposes the FSM state encoding:
//   IDLE=0, EXEC=1, RESP=2, MUL_ADD=3, MUL_SHIFT=4.
module alu_arb_seq #(
    parameter int WIDTH = 4,
    parameter bit RR_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [3:0]       req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [3:0]       req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic             resp_id,
    output logic [WIDTH-1:0] resp_data,
    output logic             resp_carry,
    output logic             resp_err,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [3:0]       alu_sel,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_carry,
    output logic [2:0]       dbg_state
);

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SHL = 4'b0100;
    localparam logic [3:0] OP_SHR = 4'b0101;
    localparam logic [3:0] OP_AND = 4'b1000;
    localparam logic [3:0] OP_OR  = 4'b1001;
    localparam logic [3:0] OP_XOR = 4'b1010;
`ifdef ALU_ARB_MUL_EN
    localparam logic [3:0] OP_MUL = 4'b0010;
    localparam int         IT_W   = $clog2(WIDTH + 1);
`endif

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_EXEC      = 3'd1,
        S_RESP      = 3'd2
`ifdef ALU_ARB_MUL_EN
        ,
        S_MUL_ADD   = 3'd3,
        S_MUL_SHIFT = 3'd4
`endif
    } state_t;

    state_t           state;
    logic             last_grant;
    logic [3:0]       op_r;
    logic             grant0;
    logic             grant1;
    logic             accept;
    logic [3:0]       sel_op;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;
    logic             sel_single;

`ifdef ALU_ARB_MUL_EN
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] mc;
    logic [WIDTH-1:0] mp;
    logic             ovf;
    logic [IT_W-1:0]  it;
    logic             shift_ovf;

    // A multiplicand bit shifted out while multiplier bits remain means the true product overflows.
    assign shift_ovf = mc[WIDTH-1] & (|mp[WIDTH-1:1]);
`endif

    assign dbg_state  = state;
    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign accept     = grant0 | grant1;

    // Arbitration: only in IDLE; on a tie, round-robin picks the requester that did not win last time.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (state == S_IDLE) begin
            if (req0_valid && req1_valid) begin
                if (RR_EN && !last_grant) begin
                    grant1 = 1'b1;
                end else begin
                    grant0 = 1'b1;
                end
            end else if (req0_valid) begin
                grant0 = 1'b1;
            end else if (req1_valid) begin
                grant1 = 1'b1;
            end
        end
    end

    // Payload mux for the granted requester and classification of its op code.
    always_comb begin
        sel_op = grant1 ? req1_op : req0_op;
        sel_a  = grant1 ? req1_a  : req0_a;
        sel_b  = grant1 ? req1_b  : req0_b;
        case (sel_op)
            OP_ADD, OP_SHL, OP_SHR, OP_AND, OP_OR, OP_XOR: sel_single = 1'b1;
            default:                                       sel_single = 1'b0;
        endcase
    end

    // Sequencer FSM. ALU inputs are registered so they are stable for the whole EXEC or MUL cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            last_grant <= 1'b1;
            op_r       <= 4'b0000;
            resp_valid <= 1'b0;
            resp_id    <= 1'b0;
            resp_data  <= '0;
            resp_carry <= 1'b0;
            resp_err   <= 1'b0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_sel    <= 4'b0000;
`ifdef ALU_ARB_MUL_EN
            acc        <= '0;
            mc         <= '0;
            mp         <= '0;
            ovf        <= 1'b0;
            it         <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        last_grant <= grant1;
                        resp_id    <= grant1;
                        op_r       <= sel_op;
                        if (sel_single) begin
                            state   <= S_EXEC;
                            alu_a   <= sel_a;
                            alu_b   <= sel_b;
                            alu_sel <= sel_op;
                        end
`ifdef ALU_ARB_MUL_EN
                        else if (sel_op == OP_MUL) begin
                            state   <= S_MUL_ADD;
                            acc     <= '0;
                            mc      <= sel_a;
                            mp      <= sel_b;
                            ovf     <= 1'b0;
                            it      <= '0;
                            alu_a   <= '0;
                            alu_b   <= sel_a;
                            alu_sel <= OP_ADD;
                        end
`endif
                        else begin
                            state      <= S_RESP;
                            resp_valid <= 1'b1;
                            resp_data  <= '0;
                            resp_carry <= 1'b0;
                            resp_err   <= 1'b1;
                        end
                    end
                end
                S_EXEC: begin
                    state      <= S_RESP;
                    resp_valid <= 1'b1;
                    resp_data  <= alu_out;
                    resp_carry <= (op_r == OP_ADD) ? alu_carry : 1'b0;
                    resp_err   <= 1'b0;
                    alu_a      <= '0;
                    alu_b      <= '0;
                    alu_sel    <= 4'b0000;
                end
`ifdef ALU_ARB_MUL_EN
                S_MUL_ADD: begin
                    if (mp[0]) begin
                        acc <= alu_out;
                        ovf <= ovf | alu_carry;
                    end
                    state   <= S_MUL_SHIFT;
                    alu_a   <= mc;
                    alu_b   <= '0;
                    alu_sel <= OP_SHL;
                end
                S_MUL_SHIFT: begin
                    mc <= alu_out;
                    mp <= mp >> 1;
                    it <= it + 1'b1;
                    if (shift_ovf) begin
                        ovf <= 1'b1;
                    end
                    if (it == IT_W'(WIDTH - 1)) begin
                        state      <= S_RESP;
                        resp_valid <= 1'b1;
                        resp_data  <= acc;
                        resp_carry <= ovf | shift_ovf;
                        resp_err   <= 1'b0;
                        alu_a      <= '0;
                        alu_b      <= '0;
                        alu_sel    <= 4'b0000;
                    end else begin
                        state   <= S_MUL_ADD;
                        alu_a   <= acc;
                        alu_b   <= alu_out;
                        alu_sel <= OP_ADD;
                    end
                end
`endif
                S_RESP: begin
                    if (resp_ready) begin
                        state      <= S_IDLE;
                        resp_valid <= 1'b0;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arb_seq.sv
// Testbench for alu_arb_seq.
// It contains a behavioural model of the ALU, a table of directed vectors, and random single requests.
// It also has hand-written sequences for: round-robin ties, response back-pressure, and reset in mid-operation.
// A scoreboard queue receives each expected response when its request is accepted.
module tb_alu_arb_seq;

    localparam int W     = 4;
    localparam bit TB_RR = 1'b1;
`ifdef ALU_ARB_MUL_EN
    localparam bit MUL_ON = 1'b1;
`else
    localparam bit MUL_ON = 1'b0;
`endif

    logic         clk;
    logic         rst;
    logic         req0_valid, req0_ready, req1_valid, req1_ready;
    logic [3:0]   req0_op, req1_op;
    logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
    logic         resp_valid, resp_ready, resp_id, resp_carry, resp_err;
    logic [W-1:0] resp_data;
    logic [W-1:0] alu_a, alu_b, alu_out;
    logic [3:0]   alu_sel;
    logic         alu_carry;
    logic [2:0]   dbg_state;

    // Scoreboard entry layout: {id, err, carry, data}
    logic [6:0] exp_q[$];
    logic [6:0] mon_exp;
    int n_cmp = 0;
    int n_fail = 0;

    typedef struct {
        logic       rid;
        logic [3:0] op;
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] data;
        logic       carry;
        logic       err;
    } vec_t;

    vec_t vecs[15];
    logic [3:0] op_list[9];

    alu_arb_seq #(.WIDTH(W), .RR_EN(TB_RR)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
        .resp_data(resp_data), .resp_carry(resp_carry), .resp_err(resp_err),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
        .alu_out(alu_out), .alu_carry(alu_carry), .dbg_state(dbg_state)
    );

    // ALU model. Carry is always the carry out of A+B.
    always_comb begin
        logic [W:0] s;
        s         = {1'b0, alu_a} + {1'b0, alu_b};
        alu_carry = s[W];
        case (alu_sel)
            4'b0000: alu_out = s[W-1:0];
            4'b0100: alu_out = alu_a << 1;
            4'b0101: alu_out = alu_a >> 1;
            4'b1000: alu_out = alu_a & alu_b;
            4'b1001: alu_out = alu_a | alu_b;
            4'b1010: alu_out = alu_a ^ alu_b;
            default: alu_out = '0;
        endcase
    end

    // Clock and watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] model(input logic id, input logic [3:0] op,
                                         input logic [3:0] a, input logic [3:0] b);
        logic [4:0] s;
        logic [3:0] d;
        logic c, e;
`ifdef ALU_ARB_MUL_EN
        logic [7:0] p;
        p = {4'b0, a} * {4'b0, b};
`endif
        s = {1'b0, a} + {1'b0, b};
        d = 4'b0; c = 1'b0; e = 1'b0;
        case (op)
            4'b0000: begin d = s[3:0]; c = s[4]; end
            4'b0100: d = a << 1;
            4'b0101: d = a >> 1;
            4'b1000: d = a & b;
            4'b1001: d = a | b;
            4'b1010: d = a ^ b;
`ifdef ALU_ARB_MUL_EN
            4'b0010: begin d = p[3:0]; c = |p[7:4]; end
`endif
            default: e = 1'b1;
        endcase
        return {id, e, c, d};
    endfunction

    function automatic logic is_single(input logic [3:0] op);
        return (op == 4'b0000) || (op == 4'b0100) || (op == 4'b0101) ||
               (op == 4'b1000) || (op == 4'b1001) || (op == 4'b1010);
    endfunction

    function automatic int lat_of(input logic [3:0] op);
        if (is_single(op)) return 2;
        if (MUL_ON && op == 4'b0010) return 2 * W + 1;
        return 1;
    endfunction

    // Response monitor: compares every consumed response against the queue head.
    always @(negedge clk) begin
        if (!rst && resp_valid && resp_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_resp: got id=%0d data=%0d, expected no response", resp_id, resp_data);
            end else begin
                mon_exp = exp_q.pop_front();
                check("resp", {25'b0, resp_id, resp_err, resp_carry, resp_data}, {25'b0, mon_exp});
            end
        end
    end

    // Driver tasks
    task automatic drive_req(input logic rid, input logic [3:0] op, input logic [3:0] a, input logic [3:0] b);
        @(posedge clk);
        #1;
        if (rid == 1'b0) begin
            req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b;
        end else begin
            req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b;
        end
    endtask

    // Waits for the grant. Returns after the accepting edge, with that requester's valid dropped.
    task automatic wait_accept(input logic rid, input logic [6:0] exp, output int waited);
        logic ok;
        ok = 1'b0;
        waited = 0;
        while (!ok && waited < 20) begin
            @(negedge clk);
            waited++;
            if ((rid == 1'b0 && req0_ready) || (rid == 1'b1 && req1_ready)) ok = 1'b1;
        end
        if (!ok) begin
            check("accept_timeout", 32'd0, 32'd1);
        end else begin
            exp_q.push_back(exp);
        end
        @(posedge clk);
        #1;
        if (rid == 1'b0) req0_valid = 1'b0;
        else req1_valid = 1'b0;
    endtask

    // Counts edges from the accepting edge (counted as 1) until resp_valid is seen.
    task automatic wait_resp(input int lat_exp, input logic [3:0] sel1, input logic [3:0] a1);
        int lat;
        lat = 1;
        @(negedge clk);
        check("alu_sel_first", {28'b0, alu_sel}, {28'b0, sel1});
        check("alu_a_first", {28'b0, alu_a}, {28'b0, a1});
        while (!resp_valid && lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        check("latency", lat, lat_exp);
        check("alu_sel_resp", {28'b0, alu_sel}, 32'd0);
        check("alu_a_resp", {28'b0, alu_a}, 32'd0);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("drain", exp_q.size(), 0);
    endtask

    // Both requesters are valid every cycle with op 1010. Checks the grant order.
    task automatic run_ties(input int n, input logic first);
        int got, cyc;
        logic expg, g;
        got = 0; cyc = 0; expg = first;
        @(posedge clk);
        #1;
        req0_valid = 1'b1; req0_op = 4'b1010; req0_a = 4'd5;  req0_b = 4'd3;
        req1_valid = 1'b1; req1_op = 4'b1010; req1_a = 4'd12; req1_b = 4'd9;
        while (got < n && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (req0_ready && req1_ready) begin
                check("both_ready", 32'd1, 32'd0);
            end else if (req0_ready || req1_ready) begin
                g = req1_ready;
                check("grant", {31'b0, g}, {31'b0, expg});
                exp_q.push_back(g ? model(1'b1, 4'b1010, 4'd12, 4'd9) : model(1'b0, 4'b1010, 4'd5, 4'd3));
                expg = TB_RR ? ~expg : 1'b0;
                got++;
            end
        end
        if (got < n) check("tie_timeout", got, n);
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        drain();
    endtask

    // Main sequence
    initial begin
        int w;
        logic rid;
        logic [3:0] op, a, b;

        rst = 1'b1; resp_ready = 1'b1;
        req0_valid = 1'b0; req0_op = 4'b0; req0_a = '0; req0_b = '0;
        req1_valid = 1'b0; req1_op = 4'b0; req1_a = '0; req1_b = '0;

        vecs[0]  = '{1'b0, 4'b0000, 4'd9,  4'd9,  4'd2,  1'b1, 1'b0};
        vecs[1]  = '{1'b1, 4'b0100, 4'd11, 4'd7,  4'd6,  1'b0, 1'b0};
        vecs[2]  = '{1'b0, 4'b0101, 4'd13, 4'd9,  4'd6,  1'b0, 1'b0};
        vecs[3]  = '{1'b1, 4'b1000, 4'd12, 4'd10, 4'd8,  1'b0, 1'b0};
        vecs[4]  = '{1'b0, 4'b1001, 4'd5,  4'd10, 4'd15, 1'b0, 1'b0};
        vecs[5]  = '{1'b1, 4'b1010, 4'd15, 4'd6,  4'd9,  1'b0, 1'b0};
        vecs[6]  = '{1'b0, 4'b1111, 4'd7,  4'd1,  4'd0,  1'b0, 1'b1};
        vecs[7]  = '{1'b1, 4'b0011, 4'd3,  4'd3,  4'd0,  1'b0, 1'b1};
        vecs[8]  = '{1'b0, 4'b0000, 4'd7,  4'd8,  4'd15, 1'b0, 1'b0};
        vecs[9]  = '{1'b1, 4'b0000, 4'd8,  4'd8,  4'd0,  1'b1, 1'b0};
        vecs[10] = '{1'b0, 4'b0010, 4'd3,  4'd6,  MUL_ON ? 4'd2 : 4'd0,  MUL_ON, !MUL_ON};
        vecs[11] = '{1'b1, 4'b0010, 4'd5,  4'd3,  MUL_ON ? 4'd15 : 4'd0, 1'b0,   !MUL_ON};
        vecs[12] = '{1'b0, 4'b0010, 4'd15, 4'd15, MUL_ON ? 4'd1 : 4'd0,  MUL_ON, !MUL_ON};
        vecs[13] = '{1'b1, 4'b0010, 4'd4,  4'd4,  4'd0,                  MUL_ON, !MUL_ON};
        vecs[14] = '{1'b0, 4'b0010, 4'd0,  4'd9,  4'd0,                  1'b0,   !MUL_ON};

        op_list[0] = 4'b0000; op_list[1] = 4'b0100; op_list[2] = 4'b0101;
        op_list[3] = 4'b1000; op_list[4] = 4'b1001; op_list[5] = 4'b1010;
        op_list[6] = 4'b0010; op_list[7] = 4'b0011; op_list[8] = 4'b1111;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        check("rst_resp_fields", {28'b0, resp_id, resp_err, resp_carry, |resp_data}, 32'd0);
        check("rst_alu", {20'b0, alu_a, alu_b, alu_sel}, 32'd0);
        check("rst_state", {29'b0, dbg_state}, 32'd0);
        check("rst_readys", {30'b0, req0_ready, req1_ready}, 32'd0);

        // Grant alternation right after reset: 0,1,0,1
        run_ties(4, 1'b0);

        // Directed vectors
        for (int i = 0; i < 15; i++) begin
            drive_req(vecs[i].rid, vecs[i].op, vecs[i].a, vecs[i].b);
            wait_accept(vecs[i].rid, {vecs[i].rid, vecs[i].err, vecs[i].carry, vecs[i].data}, w);
            wait_resp(lat_of(vecs[i].op), is_single(vecs[i].op) ? vecs[i].op : 4'b0000,
                      is_single(vecs[i].op) ? vecs[i].a : 4'b0000);
        end

        // Random single requests
        for (int i = 0; i < 16; i++) begin
            rid = 1'($urandom_range(0, 1));
            op  = op_list[$urandom_range(0, 8)];
            a   = 4'($urandom_range(0, 15));
            b   = 4'($urandom_range(0, 15));
            drive_req(rid, op, a, b);
            wait_accept(rid, model(rid, op, a, b), w);
            wait_resp(lat_of(op), is_single(op) ? op : 4'b0000, is_single(op) ? a : 4'b0000);
        end
        drain();

        // Back-pressure: the response is held for 5 cycles while both requesters wait.
        @(posedge clk);
        #1 resp_ready = 1'b0;
        drive_req(1'b0, 4'b1010, 4'd6, 4'd3);
        wait_accept(1'b0, model(1'b0, 4'b1010, 4'd6, 4'd3), w);
        wait_resp(2, 4'b1010, 4'd6);
        @(posedge clk);
        #1;
        req0_valid = 1'b1; req0_op = 4'b1000; req0_a = 4'd3; req0_b = 4'd5;
        req1_valid = 1'b1; req1_op = 4'b1001; req1_a = 4'd1; req1_b = 4'd2;
        repeat (5) begin
            @(negedge clk);
            check("hold_valid", {31'b0, resp_valid}, 32'd1);
            check("hold_payload", {25'b0, resp_id, resp_err, resp_carry, resp_data}, 32'd5);
            check("hold_readys", {30'b0, req0_ready, req1_ready}, 32'd0);
        end
        @(posedge clk);
        #1 resp_ready = 1'b1;
        @(posedge clk);
        wait_accept(1'b1, model(1'b1, 4'b1001, 4'd1, 4'd2), w);
        check("accept_next", w, 1);
        wait_resp(2, 4'b1001, 4'd1);
        wait_accept(1'b0, model(1'b0, 4'b1000, 4'd3, 4'd5), w);
        wait_resp(2, 4'b1000, 4'd3);
        drain();

        // Reset in the middle of an operation: no response, back to IDLE, and tie goes to requester 0
        if (MUL_ON) begin
            drive_req(1'b0, 4'b0010, 4'd3, 4'd6);
        end else begin
            @(posedge clk);
            #1 resp_ready = 1'b0;
            drive_req(1'b0, 4'b0000, 4'd1, 4'd2);
        end
        wait_accept(1'b0, 7'd0, w);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        exp_q.delete();
        resp_ready = 1'b1;
        @(negedge clk);
        check("midrst_valid", {31'b0, resp_valid}, 32'd0);
        check("midrst_state", {29'b0, dbg_state}, 32'd0);
        check("midrst_alu_sel", {28'b0, alu_sel}, 32'd0);
        repeat (12) @(negedge clk);
        run_ties(1, 1'b0);

        check("queue_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_arb_seq.md
Name: alu_arb_seq

Overview:
- Controller that shares one 4-bit ALU datapath (add/shl/shr/and/or/xor, carry = A+B carry) between two requesters.
- Arbitrates between the requesters, sequences single-cycle ops, and runs a multi-cycle shift-add multiply on the same ALU.
- Returns one tagged response per accepted request.
- Sits between requester logic and the ALU instance, driving all of the ALU inputs.

Parameters:
- WIDTH, 4, operand/result width; multiply runs WIDTH iterations.
- RR_EN, 1, 1 = round-robin arbitration; 0 = fixed priority, requester 0 wins.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- req0_valid  in  1  requester 0 has an op
- req0_ready  out  1  requester 0 op accepted this cycle
- req0_op  in  4  ALU select code
- req0_a, req0_b  in  WIDTH  operands
- req1_valid / req1_ready / req1_op / req1_a / req1_b  same as requester 0, for requester 1
- resp_valid  out  1  response held
- resp_ready  in  1  consumer takes response
- resp_id  out  1  requester index
- resp_data  out  WIDTH  result
- resp_carry  out  1  carry/overflow
- resp_err  out  1  unsupported op
- alu_a, alu_b  out  WIDTH  ALU operands
- alu_sel  out  4  ALU select
- alu_out  in  WIDTH  ALU result
- alu_carry  in  1  ALU add carry

Interface: one clock, clk; reset rst is synchronous and active-high.

Behaviour:
- Reset (rst high at a rising edge):
  - State returns to IDLE; any in-flight op is discarded with no response.
  - resp_valid, resp_id, resp_data, resp_carry and resp_err go to 0.
  - alu_a, alu_b and alu_sel go to 0.
  - last_grant = 1, so requester 0 wins the first tie.
- Arbitration (IDLE only):
  - reqN_ready = 1 combinationally for the granted requester only; both readys are 0 in every other state.
  - RR_EN=1: on a tie, grant the requester that is not last_grant; last_grant updates on each acceptance.
  - RR_EN=0: requester 0 always wins a tie.
- Acceptance: on the accepting edge, capture op, a, b and id.
- Op classes:
  - Supported single ops are 0000, 0100, 0101, 1000, 1001, 1010.
  - 0010 is multiply (see Optional Feature).
  - All other codes are unsupported.
- States:
  - IDLE -> EXEC for a single op.
  - IDLE -> MUL_ADD for multiply.
  - IDLE -> RESP for unsupported ops, with resp_err=1, data=0, carry=0 and no ALU cycle.
- EXEC (1 cycle): drive alu_a=a, alu_b=b, alu_sel=op; capture alu_out. resp_carry = alu_carry for 0000, else 0. Go to RESP.
- Multiply, per iteration (2 cycles):
  - Internal state: acc=0, mc=a, mp=b, ovf=0, it=0.
  - MUL_ADD: drive alu_a=acc, alu_b=mc, alu_sel=0000. If mp[0]: acc<=alu_out, ovf|=alu_carry. Go to MUL_SHIFT.
  - MUL_SHIFT: drive alu_a=mc, alu_sel=0100; mc<=alu_out; mp<=mp>>1. If mc[WIDTH-1] is set and (mp>>1)!=0, ovf<=1. it++.
  - Next state: RESP when it reaches WIDTH, else MUL_ADD.
  - Fixed 2*WIDTH cycles; result = (a*b) mod 2^WIDTH, resp_carry = ovf (true product ≥ 2^WIDTH).
- RESP:
  - resp_valid=1; data, id, carry and err are held stable while resp_ready=0.
  - On an edge with resp_ready=1: go to IDLE, resp_valid<=0.
  - No new request is accepted in the same cycle; the next acceptance is the earliest following cycle.
- ALU inputs are 0 in IDLE and RESP.
- Latency from the accepting edge to resp_valid: single op = 2 edges; multiply = 2*WIDTH+1 edges; unsupported = 1 edge.
- Requester inputs are ignored outside IDLE; requesters must hold valid and payload until ready.

Optional Feature:
- Macro ALU_ARB_MUL_EN.
- Defined: op 0010 runs the shift-add multiply described above.
- Undefined: 0010 is unsupported (resp_err=1, data=0); MUL_ADD and MUL_SHIFT states are not built.

Test Plan:
- req0 op=0000 a=9 b=9, resp_ready=1 -> resp_valid 2 edges after accept; data=2, carry=1, id=0, err=0.
- req0 and req1 both valid every cycle, op=1010 (RR_EN=1), resp_ready=1 -> grants alternate 0,1,0,1; first grant goes to 0 after reset.
- MUL enabled: 3*6 -> data=2, carry=1. 5*3 -> data=15, carry=0. Both respond exactly 9 edges after accept.
- op=1111 a=7 b=1 -> resp_valid 1 edge after accept; err=1, data=0; alu_sel stays 0 throughout.
- resp_ready held 0 for 5 cycles -> response held stable and both readys stay 0; after release, next request accepted the following cycle.
- rst pulsed mid-multiply -> next cycle resp_valid=0, state IDLE, no response emitted; next tie grants requester 0.
